// File: rtl/seq_mul_ls_param.sv
// seq_mul_ls_param
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits, for
// unsigned or two's-complement operands. Each enabled cycle adds one shifted
// partial product. Signed operands are multiplied as magnitudes, and the
// result is negated in a final fix-up cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   ce           clock enable; when low, every register holds
//   start        request, accepted only when ce=1 and the block is idle
//   signed_mode  1 = two's-complement operands, latched on an accepted start
//   a, b         multiplicand and multiplier, latched on an accepted start
//   product      2*WIDTH-bit result, held until the next accepted start
//   busy         high from the accepted start until the result is written
//   done         high for one enabled cycle when product becomes valid
module seq_mul_ls_param #(
  parameter int WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      ONE_C = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    ma, mb;
  logic                neg;
  logic [2*WIDTH-1:0]  acc;
  logic [CW-1:0]       cnt;

  // |v| as an unsigned WIDTH-bit value; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + ONE_W) : v;
  endfunction

  // Two's-complement negate; zero stays zero, so there is no negative zero.
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_P;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ce) begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (cnt == LAST) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma      <= '0;
      mb      <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (signed_mode) begin
              ma  <= magnitude(a);
              mb  <= magnitude(b);
              neg <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
              ma  <= a;
              mb  <= b;
              neg <= 1'b0;
            end
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          if (mb[cnt]) acc <= acc + ({{WIDTH{1'b0}}, ma} << cnt);
          // Hold at the last index so the counter never wraps.
          if (cnt != LAST) cnt <= cnt + ONE_C;
        end
        FIX: begin
          product <= neg ? negate(acc) : acc;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_ls_param.sv
module tb_seq_mul_ls_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        start6 = 1'b0, sm6 = 1'b0;
  logic [5:0]  a6 = '0, b6 = '0;
  logic [11:0] p6;
  logic        busy6, done6;
  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_mul_ls_param #(.WIDTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start6), .signed_mode(sm6),
    .a(a6), .b(b6), .product(p6), .busy(busy6), .done(done6)
  );

  seq_mul_ls_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .product(p8), .busy(busy8), .done(done8)
  );

  // Reference: interpret operands as w-bit numbers, multiply as integers,
  // keep the low 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                          input logic [31:0] x, input logic [31:0] y);
    longint mask, sx, sy, r;
    mask = (longint'(1) << w) - 1;
    sx = longint'(x) & mask;
    sy = longint'(y) & mask;
    if (sm && sx[w-1]) sx = sx - (longint'(1) << w);
    if (sm && sy[w-1]) sy = sy - (longint'(1) << w);
    r = sx * sy;
    return 64'(r) & ((64'd1 << (2*w)) - 64'd1);
  endfunction

  // One WIDTH=6 operation with ce=1, checking latency, busy length and result.
  task automatic op6(input bit sm, input logic [5:0] x, input logic [5:0] y, input string tag);
    int lat, bcnt;
    logic [63:0] e64;
    logic [11:0] exp;
    e64 = ref_mul(6, sm, {26'd0, x}, {26'd0, y});
    exp = e64[11:0];
    @(negedge clk);
    ce = 1'b1; sm6 = sm; a6 = x; b6 = y; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0; a6 = 6'($urandom); b6 = 6'($urandom); sm6 = 1'($urandom);
    lat = 0;
    bcnt = busy6 ? 1 : 0;
    while (!done6 && lat < 50) begin
      @(negedge clk);
      lat++;
      if (busy6) bcnt++;
    end
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, expected 7", tag, lat);
    end
    checks++;
    if (p6 !== exp) begin
      failures++;
      $display("FAIL %s product: got 0x%0h, expected 0x%0h (sm=%0d a=0x%0h b=0x%0h)", tag, p6, exp, sm, x, y);
    end
    checks++;
    if (bcnt !== 7) begin
      failures++;
      $display("FAIL %s busy_len: got %0d cycles, expected 7", tag, bcnt);
    end
  endtask

  task automatic op8(input bit sm, input logic [7:0] x, input logic [7:0] y, input string tag);
    int lat;
    logic [63:0] e64;
    logic [15:0] exp;
    e64 = ref_mul(8, sm, {24'd0, x}, {24'd0, y});
    exp = e64[15:0];
    @(negedge clk);
    ce = 1'b1; sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, expected 9", tag, lat);
    end
    checks++;
    if (p8 !== exp) begin
      failures++;
      $display("FAIL %s product: got 0x%0h, expected 0x%0h (sm=%0d a=0x%0h b=0x%0h)", tag, p8, exp, sm, x, y);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (p6 !== 12'd0 || busy6 !== 1'b0 || done6 !== 1'b0) begin
      failures++;
      $display("FAIL reset6: got p=0x%0h busy=%0b done=%0b, expected 0/0/0", p6, busy6, done6);
    end
    checks++;
    if (p8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL reset8: got p=0x%0h busy=%0b done=%0b, expected 0/0/0", p8, busy8, done8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op6(1'b0, 6'd63, 6'd63, "u63x63");
    op6(1'b1, 6'h20, 6'h20, "s_m32xm32");
    op6(1'b1, 6'h20, 6'd31, "s_m32x31");
    op6(1'b1, 6'd0, 6'h3B, "s_0xm5");
    op6(1'b0, 6'd0, 6'd0, "u0x0");
    op8(1'b0, 8'd255, 8'd255, "u8_255x255");
    op8(1'b1, 8'h80, 8'h80, "s8_m128xm128");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      op6(1'($urandom), 6'($urandom), 6'($urandom), "rand6");
    for (int i = 0; i < 8; i++)
      op8(1'($urandom), 8'($urandom), 8'($urandom), "rand8");
  endtask

  task automatic test_ce_toggle();
    int en, cyc, frozen_bad;
    logic pb, pd;
    logic [11:0] pp;
    @(negedge clk);
    ce = 1'b1; sm6 = 1'b0; a6 = 6'd13; b6 = 6'd11; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    en = 0; cyc = 0; frozen_bad = 0;
    while (!done6 && cyc < 60) begin
      ce = ~ce;
      pb = busy6; pd = done6; pp = p6;
      @(negedge clk);
      cyc++;
      if (ce) en++;
      else if (busy6 !== pb || done6 !== pd || p6 !== pp) frozen_bad++;
    end
    checks++;
    if (en !== 7) begin
      failures++;
      $display("FAIL ce_latency: got %0d enabled edges, expected 7", en);
    end
    checks++;
    if (p6 !== 12'd143) begin
      failures++;
      $display("FAIL ce_product: got %0d, expected 143", p6);
    end
    checks++;
    if (frozen_bad !== 0) begin
      failures++;
      $display("FAIL ce_freeze: got %0d changes during ce=0, expected 0", frozen_bad);
    end
    ce = 1'b0;
    @(negedge clk);
    checks++;
    if (done6 !== 1'b1) begin
      failures++;
      $display("FAIL ce_done_hold: got done=%0b, expected 1", done6);
    end
    ce = 1'b1;
    @(negedge clk);
    checks++;
    if (done6 !== 1'b0) begin
      failures++;
      $display("FAIL ce_done_clear: got done=%0b, expected 0", done6);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    ce = 1'b1; sm6 = 1'b0; a6 = 6'd9; b6 = 6'd10; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    lat = 0;
    repeat (2) begin @(negedge clk); lat++; end
    a6 = 6'd63; b6 = 6'd63; sm6 = 1'b1; start6 = 1'b1;
    @(negedge clk); lat++;
    start6 = 1'b0;
    while (!done6 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || p6 !== 12'd90) begin
      failures++;
      $display("FAIL start_ignored: got lat=%0d p=%0d, expected lat=7 p=90", lat, p6);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] e64;
    @(negedge clk);
    ce = 1'b1; sm6 = 1'b0; a6 = 6'd21; b6 = 6'd3; start6 = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!done6 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 7 || p6 !== 12'd63) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d p=%0d, expected lat=7 p=63", lat, p6);
    end
    sm6 = 1'b1; a6 = 6'h39; b6 = 6'd12;
    @(negedge clk);
    start6 = 1'b0;
    checks++;
    if (busy6 !== 1'b1 || done6 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: got busy=%0b done=%0b, expected 1/0", busy6, done6);
    end
    lat = 0;
    while (!done6 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    e64 = ref_mul(6, 1'b1, 32'h39, 32'd12);
    checks++;
    if (lat !== 7 || p6 !== e64[11:0]) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d p=0x%0h, expected lat=7 p=0x%0h", lat, p6, e64[11:0]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ce = 1'b1; sm6 = 1'b0; a6 = 6'd20; b6 = 6'd20; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (p6 !== 12'd0 || busy6 !== 1'b0 || done6 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got p=0x%0h busy=%0b done=%0b, expected 0/0/0", p6, busy6, done6);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy6 !== 1'b0 || done6 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: got busy=%0b done=%0b, expected 0/0", busy6, done6);
    end
    rst_n = 1'b1;
    op6(1'b0, 6'd5, 6'd7, "post_reset_5x7");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ce_toggle();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
